video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
Generates raster timing for the HDMI transmit path, clocked by the 27 MHz pixel clock. It produces the horizontal/vertical pixel position, the display-enable flag and the sync pulses that the pattern generator and the TMDS transmitter consume. Default timing is CEA 720x480p60 (858x525 total). All outputs are registered and mutually aligned.

Parameters:
H_ACTIVE, 720, active pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 62, hsync width in pixels
H_BACK, 60, horizontal back porch in pixels
V_ACTIVE, 480, active lines per frame
V_FRONT, 9, vertical front porch in lines
V_SYNC, 6, vsync width in lines
V_BACK, 30, vertical back porch in lines
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high); applies to both syncs
POS_W, 10, width of the position outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
pixelClock  in  1  pixel clock; all logic on its rising edge
resetN  in  1  asynchronous active-low reset
pixelEnable  in  1  clock enable; when 0, all state and outputs hold
hPosCounter  out  POS_W  horizontal position of the current output pixel
vPosCounter  out  POS_W  vertical position of the current output pixel
inActiveDisplay  out  1  1 when hPos < H_ACTIVE and vPos < V_ACTIVE
hSync  out  1  horizontal sync at SYNC_POL level during the sync interval
vSync  out  1  vertical sync at SYNC_POL level during the sync interval
lineStart  out  1  1-cycle pulse when hPos == 0
frameStart  out  1  1-cycle pulse when hPos == 0 and vPos == 0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (858); V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
- Region ordering per axis: ACTIVE [0, ACTIVE-1], FRONT, SYNC, BACK, then wrap to 0.
- Internal counters hCnt and vCnt reset to 0. On each pixelClock edge with pixelEnable=1:
  - hCnt increments; at H_TOTAL-1 it wraps to 0.
  - vCnt increments only when hCnt wraps; at V_TOTAL-1 (with hCnt wrap) it wraps to 0.
- Per-axis FSM states: ACTIVE, FRONT, SYNC, BACK. Transitions occur on count boundaries: ACTIVE->FRONT at ACTIVE, FRONT->SYNC at ACTIVE+FRONT, SYNC->BACK at ACTIVE+FRONT+SYNC, BACK->ACTIVE on wrap. The V FSM advances only on the H wrap.
- Output stage: one register stage, so latency is 1 enabled cycle.
  - hPosCounter <= hCnt and vPosCounter <= vCnt.
  - All flags are decoded from the same hCnt/vCnt, so every output describes the same pixel.
- vSync changes only together with lineStart (line granularity). vSync is asserted for exactly V_SYNC*H_TOTAL cycles.
- hSync is asserted for hPos in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1].
- Reset values: hPosCounter=0, vPosCounter=0, inActiveDisplay=0, lineStart=0, frameStart=0, hSync=vSync=~SYNC_POL (deasserted).
- First enabled edge after reset release: outputs show (0,0) with inActiveDisplay=1, lineStart=1, frameStart=1.
- pixelEnable=0: counters, FSMs and all outputs hold, including pulses. A pulse that is high remains high until the next enabled edge; this is a deliberate stall semantic.
- Reset asserted mid-frame: immediate asynchronous return to reset values; no partial-frame completion.
- Width rule: counters are POS_W bits, with comparisons at full width. Elaboration fails if H_TOTAL or V_TOTAL exceeds 2^POS_W, or if any timing parameter is 0.

Decomposition:
- Shared package video_timing_pkg holds:
  - per-mode localparam sets (720x480p60 default, 640x480p60 alternative),
  - the axis-state enum {ACTIVE, FRONT, SYNC, BACK},
  - the derived H_TOTAL/V_TOTAL functions.
- One sub-module, timing_axis_counter (params ACTIVE/FRONT/SYNC/BACK, inputs advance, output count, state and wrap), instantiated twice. The V instance's advance input is the H instance's wrap output gated by pixelEnable.

Test Plan:
- Reset release, pixelEnable=1 -> cycle 1: hPos=0, vPos=0, inActiveDisplay=1, frameStart=1, lineStart=1. Cycle 2: hPos=1, pulses 0.
- Line scan -> inActiveDisplay falls at hPos=720; hSync=0 for hPos 736..797 (62 cycles); hPos 857 is followed by 0 with vPos incrementing to 1.
- Full frame -> frameStart repeats every 450450 enabled cycles; inActiveDisplay high for 345600 cycles per frame; vSync low for vPos 489..494, i.e. 5148 cycles, with edges coincident with lineStart.
- Wrap corner: at (857,524) the next output is (0,0) with frameStart=1, and vSync was deasserted at the preceding line boundaries.
- pixelEnable toggled 1/0 randomly -> output sequence equals the all-enabled sequence with repeated samples; a held frameStart stays 1 while disabled.
- resetN pulsed low at (400,200) -> all outputs go to reset values without waiting for a clock edge; after release the timing restarts at (0,0) with frameStart=1.

Source files
------------

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared raster timing modes, axis state type and helpers
package video_timing_pkg;

  // CEA 720x480p60, 27 MHz pixel clock
  localparam int CEA480_H_ACTIVE = 720;
  localparam int CEA480_H_FRONT  = 16;
  localparam int CEA480_H_SYNC   = 62;
  localparam int CEA480_H_BACK   = 60;
  localparam int CEA480_V_ACTIVE = 480;
  localparam int CEA480_V_FRONT  = 9;
  localparam int CEA480_V_SYNC   = 6;
  localparam int CEA480_V_BACK   = 30;

  // VGA 640x480p60, 25.175 MHz pixel clock
  localparam int VGA480_H_ACTIVE = 640;
  localparam int VGA480_H_FRONT  = 16;
  localparam int VGA480_H_SYNC   = 96;
  localparam int VGA480_H_BACK   = 48;
  localparam int VGA480_V_ACTIVE = 480;
  localparam int VGA480_V_FRONT  = 10;
  localparam int VGA480_V_SYNC   = 2;
  localparam int VGA480_V_BACK   = 33;

  // Region of one axis; ordering matches the raster: active, front porch, sync, back porch
  typedef enum logic [1:0] {
    AXIS_ACTIVE,
    AXIS_FRONT,
    AXIS_SYNC,
    AXIS_BACK
  } axisState_t;

  function automatic int axisTotal(input int active, input int front, input int sync, input int back);
    return active + front + sync + back;
  endfunction

  function automatic int hTotal(input int active, input int front, input int sync, input int back);
    return axisTotal(active, front, sync, back);
  endfunction

  function automatic int vTotal(input int active, input int front, input int sync, input int back);
    return axisTotal(active, front, sync, back);
  endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// rtl/timing_axis_counter.sv - wrapping position counter with region FSM for one raster axis
module timing_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 720,
  parameter int FRONT  = 16,
  parameter int SYNC   = 62,
  parameter int BACK   = 60,
  parameter int W      = 10
) (
  input  logic         pixelClock,
  input  logic         resetN,
  input  logic         advance,
  output logic [W-1:0] count,
  output axisState_t   state,
  output logic         wrap
);

  localparam int TOTAL = axisTotal(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [W-1:0] LAST        = W'(TOTAL - 1);
  localparam logic [W-1:0] FRONT_START = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START  = W'(ACTIVE + FRONT);
  localparam logic [W-1:0] BACK_START  = W'(ACTIVE + FRONT + SYNC);

  logic [W-1:0] nextCount;

  // wrap flags the terminal count; the caller decides whether this cycle actually advances
  assign wrap      = (count == LAST);
  assign nextCount = wrap ? '0 : count + 1'b1;

  // Count and region advance together so state always describes the registered count
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
      state <= AXIS_ACTIVE;
    end else if (advance) begin
      count <= nextCount;
      case (state)
        AXIS_ACTIVE: if (nextCount == FRONT_START) state <= AXIS_FRONT;
        AXIS_FRONT:  if (nextCount == SYNC_START)  state <= AXIS_SYNC;
        AXIS_SYNC:   if (nextCount == BACK_START)  state <= AXIS_BACK;
        AXIS_BACK:   if (wrap)                     state <= AXIS_ACTIVE;
        default:                                   state <= AXIS_ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator for the HDMI transmit path
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = CEA480_H_ACTIVE,
  parameter int H_FRONT  = CEA480_H_FRONT,
  parameter int H_SYNC   = CEA480_H_SYNC,
  parameter int H_BACK   = CEA480_H_BACK,
  parameter int V_ACTIVE = CEA480_V_ACTIVE,
  parameter int V_FRONT  = CEA480_V_FRONT,
  parameter int V_SYNC   = CEA480_V_SYNC,
  parameter int V_BACK   = CEA480_V_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int POS_W    = 10
) (
  input  logic             pixelClock,
  input  logic             resetN,
  input  logic             pixelEnable,
  output logic [POS_W-1:0] hPosCounter,
  output logic [POS_W-1:0] vPosCounter,
  output logic             inActiveDisplay,
  output logic             hSync,
  output logic             vSync,
  output logic             lineStart,
  output logic             frameStart
);

  localparam int H_TOTAL = hTotal(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vTotal(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > (1 << POS_W) || V_TOTAL > (1 << POS_W)) begin : gPosWidthCheck
    $error("video_timing_gen: POS_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
      V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : gZeroParamCheck
    $error("video_timing_gen: timing parameters must be non-zero");
  end

  logic [POS_W-1:0] hCnt;
  logic [POS_W-1:0] vCnt;
  axisState_t       hState;
  axisState_t       vState;
  logic             hWrap;
  logic             vAdvance;

  // Lines advance only on an enabled horizontal wrap
  assign vAdvance = hWrap & pixelEnable;

  timing_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(POS_W)
  ) uHAxis (
    .pixelClock(pixelClock),
    .resetN    (resetN),
    .advance   (pixelEnable),
    .count     (hCnt),
    .state     (hState),
    .wrap      (hWrap)
  );

  timing_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(POS_W)
  ) uVAxis (
    .pixelClock(pixelClock),
    .resetN    (resetN),
    .advance   (vAdvance),
    .count     (vCnt),
    .state     (vState),
    .wrap      ()
  );

  // One output stage decoded from the same counter snapshot keeps every output on the same pixel
  always_ff @(posedge pixelClock or negedge resetN) begin
    if (!resetN) begin
      hPosCounter     <= '0;
      vPosCounter     <= '0;
      inActiveDisplay <= 1'b0;
      hSync           <= ~SYNC_POL;
      vSync           <= ~SYNC_POL;
      lineStart       <= 1'b0;
      frameStart      <= 1'b0;
    end else if (pixelEnable) begin
      hPosCounter     <= hCnt;
      vPosCounter     <= vCnt;
      inActiveDisplay <= (hState == AXIS_ACTIVE) && (vState == AXIS_ACTIVE);
      hSync           <= (hState == AXIS_SYNC) ? SYNC_POL : ~SYNC_POL;
      vSync           <= (vState == AXIS_SYNC) ? SYNC_POL : ~SYNC_POL;
      lineStart       <= (hCnt == '0);
      frameStart      <= (hCnt == '0) && (vCnt == '0);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - self-checking bench for video_timing_gen
module tb_video_timing_gen;

  logic pixelClock = 1'b0;
  logic resetN     = 1'b0;
  logic enA        = 1'b0;
  logic enB        = 1'b0;

  always #5 pixelClock = ~pixelClock;

  // Default CEA 720x480p60 instance for line-level checks
  logic [9:0] hA, vA;
  logic       deA, hsA, vsA, lsA, fsA;

  video_timing_gen dutA (
    .pixelClock     (pixelClock),
    .resetN         (resetN),
    .pixelEnable    (enA),
    .hPosCounter    (hA),
    .vPosCounter    (vA),
    .inActiveDisplay(deA),
    .hSync          (hsA),
    .vSync          (vsA),
    .lineStart      (lsA),
    .frameStart     (fsA)
  );

  // Miniature raster (15x8 total, active-high syncs) for whole-frame checks
  logic [3:0] hB, vB;
  logic       deB, hsB, vsB, lsB, fsB;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(1'b1), .POS_W(4)
  ) dutB (
    .pixelClock     (pixelClock),
    .resetN         (resetN),
    .pixelEnable    (enB),
    .hPosCounter    (hB),
    .vPosCounter    (vB),
    .inActiveDisplay(deB),
    .hSync          (hsB),
    .vSync          (vsB),
    .lineStart      (lsB),
    .frameStart     (fsB)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge pixelClock);
    @(negedge pixelClock);
  endtask

  function automatic logic [24:0] packA();
    return {hA, vA, deA, hsA, vsA, lsA, fsA};
  endfunction

  function automatic logic [12:0] packB();
    return {hB, vB, deB, hsB, vsB, lsB, fsB};
  endfunction

  // Independent reference for dutB: pixel index p -> expected outputs
  function automatic logic [12:0] expB(input int p);
    int h = p % 15;
    int v = (p / 15) % 8;
    logic de = (h < 8) && (v < 4);
    logic hs = (h >= 10) && (h <= 12);
    logic vs = (v >= 5) && (v <= 6);
    logic ls = (h == 0);
    logic fs = (h == 0) && (v == 0);
    return {4'(h), 4'(v), de, hs, vs, ls, fs};
  endfunction

  localparam logic [24:0] RESET_A = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [12:0] RESET_B = 13'd0;

  typedef struct {
    int         cyc;
    logic [9:0] h;
    logic [9:0] v;
    logic       de;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } vecA_t;

  vecA_t vecs[11];

  initial begin
    int idx;
    int p;
    int guard;
    int deCount, vsCount, fsCount, fsFirst, fsGap, vsBad;
    logic prevVs;

    vecs[0]  = '{1,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[1]  = '{2,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{720, 10'd719, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{721, 10'd720, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{736, 10'd735, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{737, 10'd736, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{798, 10'd797, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{799, 10'd798, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{858, 10'd857, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{859, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{860, 10'd1,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    check("resetA", 32'(packA()), 32'(RESET_A));
    check("resetB", 32'(packB()), 32'(RESET_B));

    // Default-mode line scan driven by the vector table
    resetN = 1'b1;
    enA    = 1'b1;
    idx    = 0;
    for (int k = 1; k <= 860; k++) begin
      tick();
      if (idx < 11 && vecs[idx].cyc == k) begin
        check($sformatf("lineA_cyc%0d", k), 32'(packA()),
              32'({vecs[idx].h, vecs[idx].v, vecs[idx].de, vecs[idx].hs,
                   vecs[idx].vs, vecs[idx].ls, vecs[idx].fs}));
        idx++;
      end
    end
    enA = 1'b0;
    check("idleB", 32'(packB()), 32'(RESET_B));

    // Miniature raster, all enabled: two frames plus a margin
    enB = 1'b1;
    p = -1;
    deCount = 0; vsCount = 0; fsCount = 0; fsFirst = -1; fsGap = 0; vsBad = 0;
    prevVs = 1'b0;
    for (int n = 0; n < 250; n++) begin
      tick();
      p++;
      check($sformatf("frameB_p%0d", p), 32'(packB()), 32'(expB(p)));
      if (p < 120) begin
        deCount += int'(deB);
        vsCount += int'(vsB);
      end
      if (fsB) begin
        fsCount++;
        if (fsFirst < 0) fsFirst = p;
        else if (fsGap == 0) fsGap = p - fsFirst;
      end
      if (vsB != prevVs && !lsB) vsBad++;
      prevVs = vsB;
    end
    check("frameB_deCount", 32'(deCount), 32'd32);
    check("frameB_vsCount", 32'(vsCount), 32'd30);
    check("frameB_fsCount", 32'(fsCount), 32'd3);
    check("frameB_fsGap",   32'(fsGap),   32'd120);
    check("frameB_vsEdges", 32'(vsBad),   32'd0);

    // Random stalls: output sequence is the enabled sequence with repeats
    for (int n = 0; n < 300; n++) begin
      enB = 1'($urandom_range(0, 1));
      tick();
      if (enB) p++;
      check($sformatf("stallB_n%0d", n), 32'(packB()), 32'(expB(p)));
    end

    // A held frameStart stays high while disabled
    enB = 1'b1;
    guard = 0;
    do begin
      tick();
      p++;
      guard++;
    end while (!fsB && guard < 300);
    check("holdB_found", 32'(guard < 300), 32'd1);
    enB = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("holdB_fs%0d", n), 32'(packB()), 32'(expB(p)));
    end

    // Move to pixel (6,2), then reset asynchronously between clock edges
    enB = 1'b1;
    guard = 0;
    while ((p % 120) != 36 && guard < 300) begin
      tick();
      p++;
      guard++;
    end
    check("seekB", 32'(packB()), 32'(expB(36)));
    enB = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    check("asyncResetA", 32'(packA()), 32'(RESET_A));
    check("asyncResetB", 32'(packB()), 32'(RESET_B));
    @(negedge pixelClock);
    resetN = 1'b1;
    enB    = 1'b1;
    tick();
    check("restartB_p0", 32'(packB()), 32'(expB(0)));
    tick();
    check("restartB_p1", 32'(packB()), 32'(expB(1)));
    check("restartA_hold", 32'(packA()), 32'(RESET_A));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
